// File: rtl/grid_renderer_pipe_if.sv
// Beam, sprite, board-status and cursor bundle feeding the grid renderer,
// plus the pixel colour and animation status it returns.
interface grid_renderer_pipe_if #(
   parameter int ROWS = 10,
   parameter int COLS = 10
);
   logic                       bright;
   logic [9:0]                 hCount;
   logic [9:0]                 vCount;
   logic [11:0]                sprite_color;
   logic                       in_sprite;
   logic [2*ROWS*COLS-1:0]     cell_status_flat;
   logic                       cursor_en;
   logic [3:0]                 cursor_row;
   logic [3:0]                 cursor_col;
   logic                       frame_tick;
   logic [11:0]                rgb;
   logic                       blink_phase;
   logic                       flash_active;

   modport master (
      output bright, hCount, vCount, sprite_color, in_sprite, cell_status_flat,
             cursor_en, cursor_row, cursor_col, frame_tick,
      input  rgb, blink_phase, flash_active
   );

   modport slave (
      input  bright, hCount, vCount, sprite_color, in_sprite, cell_status_flat,
             cursor_en, cursor_row, cursor_col, frame_tick,
      output rgb, blink_phase, flash_active
   );
endinterface

// File: rtl/grid_renderer_pipe.sv
// Two-stage board pixel renderer: beam -> cell mapping, then colour select with
// sprite overlay, last-changed-cell flash, blinking cursor and grid lines.
module grid_renderer_pipe #(
   parameter int          ROWS         = 10,
   parameter int          COLS         = 10,
   parameter int          GRID_LEFT    = 144,
   parameter int          GRID_TOP     = 35,
   parameter int          CELL_W       = 64,
   parameter int          CELL_H       = 48,
   parameter int          LINE_THICK   = 1,
   parameter int          BLINK_FRAMES = 15,
   parameter int          FLASH_FRAMES = 8,
   parameter logic [11:0] SPRITE_KEY   = 12'h00F
) (
   input  logic                 clk,
   input  logic                 reset,
   grid_renderer_pipe_if.slave  bus
);
   localparam int NCELL       = ROWS * COLS;
   localparam int GRID_RIGHT  = GRID_LEFT + CELL_W * COLS;
   localparam int GRID_BOTTOM = GRID_TOP + CELL_H * ROWS;
   localparam int BW          = $clog2(BLINK_FRAMES) + 1;
   localparam int FW          = $clog2(FLASH_FRAMES + 1);

   localparam logic [11:0] C_BLACK  = 12'h000;
   localparam logic [11:0] C_WHITE  = 12'hFFF;
   localparam logic [11:0] C_BLUE   = 12'h00F;
   localparam logic [11:0] C_GRAY   = 12'h888;
   localparam logic [11:0] C_RED    = 12'hF00;
   localparam logic [11:0] C_YELLOW = 12'hFF0;

   // ---------------- stage 1: beam to cell mapping ----------------
   logic [9:0] w_x, w_y;
   logic       w_in_grid, w_is_line;
   logic [3:0] w_row, w_col;

   assign w_x       = bus.hCount - 10'(GRID_LEFT);
   assign w_y       = bus.vCount - 10'(GRID_TOP);
   assign w_in_grid = bus.bright
                      && int'(bus.hCount) >= GRID_LEFT && int'(bus.hCount) < GRID_RIGHT
                      && int'(bus.vCount) >= GRID_TOP  && int'(bus.vCount) < GRID_BOTTOM;
   assign w_row     = 4'(w_y / 10'(CELL_H));
   assign w_col     = 4'(w_x / 10'(CELL_W));
   assign w_is_line = w_in_grid && ((w_x % 10'(CELL_W)) < 10'(LINE_THICK)
                                 || (w_y % 10'(CELL_H)) < 10'(LINE_THICK));

   logic        r_s1_in_grid, r_s1_is_line, r_s1_bright, r_s1_in_sprite;
   logic [3:0]  r_s1_row, r_s1_col;
   logic [11:0] r_s1_sprite_color;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_in_grid      <= 1'b0;
         r_s1_is_line      <= 1'b0;
         r_s1_bright       <= 1'b0;
         r_s1_in_sprite    <= 1'b0;
         r_s1_row          <= '0;
         r_s1_col          <= '0;
         r_s1_sprite_color <= '0;
      end else begin
         r_s1_in_grid      <= w_in_grid;
         r_s1_is_line      <= w_is_line;
         r_s1_bright       <= bus.bright;
         r_s1_in_sprite    <= bus.in_sprite;
         r_s1_row          <= w_row;
         r_s1_col          <= w_col;
         r_s1_sprite_color <= bus.sprite_color;
      end
   end

   // ---------------- change detector and flash timer ----------------
   logic [2*NCELL-1:0] r_prev_status;
   logic               r_primed;
   logic [NCELL-1:0]   w_chg;
   logic [7:0]         w_chg_idx;
   logic [7:0]         r_flash_idx;
   logic [FW-1:0]      r_flash_cnt;
   logic               w_flash_active;
   logic [1:0]         w_cell_st [NCELL];

   genvar gi;
   generate
      for (gi = 0; gi < NCELL; gi++) begin : g_cell
         assign w_cell_st[gi] = bus.cell_status_flat[2*gi +: 2];
         assign w_chg[gi]     = r_primed && (r_prev_status[2*gi +: 2] != w_cell_st[gi]);
      end
   endgenerate

   // Scan downward so the lowest changed index is the one left standing.
   always_comb begin
      w_chg_idx = '0;
      for (int i = NCELL - 1; i >= 0; i--) begin
         if (w_chg[i]) w_chg_idx = 8'(i);
      end
   end

   assign w_flash_active = (r_flash_cnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_status <= '0;
         r_primed      <= 1'b0;
         r_flash_idx   <= '0;
         r_flash_cnt   <= '0;
      end else begin
         r_prev_status <= bus.cell_status_flat;
         r_primed      <= 1'b1;
         if (|w_chg) begin
            r_flash_idx <= w_chg_idx;
            r_flash_cnt <= FW'(FLASH_FRAMES);
         end else if (bus.frame_tick && w_flash_active) begin
            r_flash_cnt <= r_flash_cnt - FW'(1);
         end
      end
   end

   // ---------------- cursor blink timer ----------------
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_phase;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (bus.frame_tick) begin
         if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
         end
      end
   end

   // ---------------- stage 2: colour select ----------------
   logic [7:0]  w_cell_idx;
   logic [1:0]  w_status;
   logic        w_flash_hit, w_cursor_hit;
   logic [11:0] w_status_rgb, w_rgb_next;
   logic [11:0] r_rgb;

   assign w_cell_idx = 8'(int'(r_s1_row) * COLS + int'(r_s1_col));

   always_comb begin
      w_status = 2'b00;
      for (int i = 0; i < NCELL; i++) begin
         if (w_cell_idx == 8'(i)) w_status = w_cell_st[i];
      end
   end

   always_comb begin
      case (w_status)
         2'b00:   w_status_rgb = C_BLUE;
         2'b01:   w_status_rgb = C_GRAY;
         2'b10:   w_status_rgb = C_BLACK;
         default: w_status_rgb = C_RED;
      endcase
   end

   assign w_flash_hit  = r_s1_in_grid && w_flash_active && r_flash_cnt[0]
                         && (w_cell_idx == r_flash_idx) && !r_s1_is_line;
   // Out-of-range cursor coordinates must never alias onto a real cell.
   assign w_cursor_hit = r_s1_in_grid && bus.cursor_en && r_blink_phase
                         && int'(bus.cursor_row) < ROWS && int'(bus.cursor_col) < COLS
                         && (r_s1_row == bus.cursor_row) && (r_s1_col == bus.cursor_col)
                         && !r_s1_is_line;

   always_comb begin
      w_rgb_next = C_BLACK;
      if (!r_s1_bright)                                          w_rgb_next = C_BLACK;
      else if (r_s1_in_sprite && r_s1_sprite_color != SPRITE_KEY) w_rgb_next = r_s1_sprite_color;
      else if (w_flash_hit)                                      w_rgb_next = C_WHITE;
      else if (w_cursor_hit)                                     w_rgb_next = C_YELLOW;
      else if (r_s1_is_line)                                     w_rgb_next = C_WHITE;
      else if (r_s1_in_grid)                                     w_rgb_next = w_status_rgb;
   end

   always_ff @(posedge clk) begin
      if (reset) r_rgb <= C_BLACK;
      else       r_rgb <= w_rgb_next;
   end

   assign bus.rgb          = r_rgb;
   assign bus.blink_phase  = r_blink_phase;
   assign bus.flash_active = w_flash_active;
endmodule

// File: tb/tb_grid_renderer_pipe.sv
// Directed-vector bench for grid_renderer_pipe with BLINK_FRAMES=2, other
// parameters at their defaults; expected colours are worked out by hand.
module tb_grid_renderer_pipe;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   grid_renderer_pipe_if #(.ROWS(10), .COLS(10)) bus ();

   grid_renderer_pipe #(.BLINK_FRAMES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame();
      bus.frame_tick = 1'b1;
      step(1);
      bus.frame_tick = 1'b0;
   endtask

   task automatic pix(input int h, input int v);
      bus.hCount = 10'(h);
      bus.vCount = 10'(v);
      step(2);
   endtask

   task automatic set_cell(input int idx, input logic [1:0] val);
      bus.cell_status_flat[2*idx +: 2] = val;
   endtask

   initial begin
      reset = 1'b1;
      bus.bright = 1'b0;
      bus.hCount = '0;
      bus.vCount = '0;
      bus.sprite_color = '0;
      bus.in_sprite = 1'b0;
      bus.cell_status_flat = '0;
      bus.cursor_en = 1'b0;
      bus.cursor_row = '0;
      bus.cursor_col = '0;
      bus.frame_tick = 1'b0;
      step(2);
      chk("reset_rgb", 32'(bus.rgb), 32'h000);
      chk("reset_blink", 32'(bus.blink_phase), 32'd0);
      chk("reset_flash", 32'(bus.flash_active), 32'd0);
      reset = 1'b0;

      bus.bright = 1'b1;
      pix(144, 35);
      chk("corner_line", 32'(bus.rgb), 32'hFFF);
      pix(150, 40);
      chk("water_cell", 32'(bus.rgb), 32'h00F);

      // Cell (2,3) -> index 23, sunk.
      set_cell(23, 2'b11);
      pix(144 + 3*64 + 10, 35 + 2*48 + 10);
      chk("sunk_cell", 32'(bus.rgb), 32'hF00);
      chk("flash_idx_23", 32'(dut.r_flash_idx), 32'd23);
      bus.bright = 1'b0;
      step(2);
      chk("blank", 32'(bus.rgb), 32'h000);
      bus.bright = 1'b1;

      bus.in_sprite = 1'b1;
      bus.sprite_color = 12'h0F0;
      pix(144, 35);
      chk("sprite_over_line", 32'(bus.rgb), 32'h0F0);
      bus.sprite_color = 12'h00F;
      step(2);
      chk("sprite_key", 32'(bus.rgb), 32'hFFF);
      bus.in_sprite = 1'b0;

      // Odd flash count lights the flashed cell white, even shows status.
      pix(144 + 3*64 + 10, 35 + 2*48 + 10);
      frame();
      step(2);
      chk("flash_cnt_7", 32'(dut.r_flash_cnt), 32'd7);
      chk("flash_white", 32'(bus.rgb), 32'hFFF);
      frame();
      step(2);
      chk("flash_even", 32'(bus.rgb), 32'hF00);

      // Status held through reset must not flash.
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(3);
      chk("held_status_noflash", 32'(bus.flash_active), 32'd0);

      bus.cursor_en = 1'b1;
      bus.cursor_row = 4'd4;
      bus.cursor_col = 4'd4;
      pix(144 + 4*64 + 10, 35 + 4*48 + 10);
      chk("cursor_phase0_rgb", 32'(bus.rgb), 32'h00F);
      frame();
      chk("blink_after1", 32'(bus.blink_phase), 32'd0);
      frame();
      chk("blink_after2", 32'(bus.blink_phase), 32'd1);
      step(2);
      chk("cursor_on", 32'(bus.rgb), 32'hFF0);
      frame();
      frame();
      chk("blink_after4", 32'(bus.blink_phase), 32'd0);
      step(2);
      chk("cursor_off", 32'(bus.rgb), 32'h00F);
      frame();
      frame();
      bus.cursor_row = 4'd12;
      step(2);
      chk("cursor_row12", 32'(bus.rgb), 32'h00F);
      bus.cursor_row = 4'd4;
      step(2);
      chk("cursor_back", 32'(bus.rgb), 32'hFF0);
      bus.cursor_en = 1'b0;

      set_cell(7, 2'b01);
      set_cell(5, 2'b01);
      step(2);
      chk("flash_idx_5", 32'(dut.r_flash_idx), 32'd5);
      chk("flash_cnt_8", 32'(dut.r_flash_cnt), 32'd8);
      chk("flash_active", 32'(bus.flash_active), 32'd1);
      repeat (4) frame();
      chk("flash_cnt_4", 32'(dut.r_flash_cnt), 32'd4);
      bus.frame_tick = 1'b1;
      set_cell(9, 2'b10);
      step(1);
      bus.frame_tick = 1'b0;
      step(1);
      chk("reload_cnt", 32'(dut.r_flash_cnt), 32'd8);
      chk("reload_idx", 32'(dut.r_flash_idx), 32'd9);
      repeat (7) frame();
      chk("flash_7ticks", 32'(bus.flash_active), 32'd1);
      frame();
      chk("flash_done", 32'(bus.flash_active), 32'd0);

      set_cell(0, 2'b11);
      pix(144, 35);
      chk("preflash_active", 32'(bus.flash_active), 32'd1);
      chk("preflash_rgb", 32'(bus.rgb), 32'hFFF);
      reset = 1'b1;
      step(1);
      chk("midreset_flash", 32'(bus.flash_active), 32'd0);
      chk("midreset_rgb", 32'(bus.rgb), 32'h000);
      reset = 1'b0;
      step(2);
      chk("refill_rgb", 32'(bus.rgb), 32'hFFF);
      chk("refill_noflash", 32'(bus.flash_active), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
